// File: rtl/i2c_lut_loader.sv
// i2c_lut_loader: fills a config LUT from a framed byte stream,
// then pulses cfg_start so the config walker restarts.
module i2c_lut_loader #(
  parameter int DEPTH        = 256,
  parameter int START_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  input  logic [9:0]  lut_index,
  output logic [7:0]  lut_dev_addr,
  output logic [15:0] lut_reg_addr,
  output logic [7:0]  lut_reg_data,
  output logic        cfg_start,
  output logic [9:0]  entry_count,
  output logic        load_error,
  output logic        busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [10:0] FULL = 11'(DEPTH);

  typedef enum logic [1:0] {
    IDLE, RECV, COMMIT, START
  } state_t;

  state_t      state;
  logic [10:0] wr_ptr;
  logic [10:0] cnt_q;
  logic [1:0]  pos;
  logic        ovf;
  logic [7:0]  b0, b1, b2;
  logic [15:0] scnt;
  logic [31:0] mem [DEPTH];

  logic        idle, take, drop, wr_en, hit;
  logic [1:0]  e_pos;
  logic [10:0] e_ptr;
  logic        e_ovf;
  logic [31:0] rd;

  assign idle    = (state == IDLE);
  assign s_ready = idle || (state == RECV);
  assign busy    = !idle;
  assign take    = s_valid && s_ready;

  // First byte of a frame behaves as if the counters were already cleared
  assign e_pos = idle ? 2'd0 : pos;
  assign e_ptr = idle ? 11'd0 : wr_ptr;
  assign e_ovf = idle ? 1'b0 : ovf;

  assign drop  = e_ovf || (e_pos == 2'd0 && e_ptr == FULL);
  assign wr_en = take && !drop && (e_pos == 2'd3);

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[e_ptr[AW-1:0]] <= {b0, b1, b2, s_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      cnt_q      <= '0;
      pos        <= '0;
      ovf        <= 1'b0;
      b0         <= '0;
      b1         <= '0;
      b2         <= '0;
      scnt       <= '0;
      load_error <= 1'b0;
      cfg_start  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, RECV: begin
          if (take) begin
            wr_ptr <= e_ptr + 11'(wr_en);
            ovf    <= drop;
            pos    <= drop ? e_pos : e_pos + 2'd1;
            if (!drop && e_pos == 2'd0) b0 <= s_data;
            if (!drop && e_pos == 2'd1) b1 <= s_data;
            if (!drop && e_pos == 2'd2) b2 <= s_data;
            if (drop || (s_last && e_pos != 2'd3))
              load_error <= 1'b1;
            else if (idle)
              load_error <= 1'b0;
            state <= s_last ? COMMIT : RECV;
          end
        end
        COMMIT: begin
          cnt_q     <= wr_ptr;
          cfg_start <= 1'b1;
          scnt      <= 16'(START_CYCLES - 1);
          state     <= START;
        end
        START: begin
          if (scnt == 16'd0) begin
            cfg_start <= 1'b0;
            state     <= IDLE;
          end else begin
            scnt <= scnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reads past the committed count, or mid-load, see a terminator
  assign rd  = mem[lut_index[AW-1:0]];
  assign hit = !busy && ({1'b0, lut_index} < cnt_q);

  assign lut_dev_addr = hit ? rd[31:24] : 8'hFF;
  assign lut_reg_addr = hit ? rd[23:8]  : 16'h0000;
  assign lut_reg_data = hit ? rd[7:0]   : 8'h00;

  assign entry_count = cnt_q[10] ? 10'h3FF : cnt_q[9:0];

endmodule
